bitwise_pipe: RTL and testbench
===============================

# bitwise_pipe

Parametrised, registered successor to the 16-bit inverter: a WIDTH-bit bitwise logic unit with eight selectable operations, a valid/ready input and output handshake, and a DEPTH-entry result FIFO. Operands are accepted one per cycle, evaluated combinationally, and queued so a stalled consumer never loses a result. It sits between the Week 1 gate library and the Week 2/3 ALU and register blocks, as a reusable back-pressured logic stage.

## Interface
- `WIDTH`, 16: operand and result width; ≥1.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  input  1  operand/op present.
- `in_ready`  output  1  block can accept this cycle.
- `in_a`  input  WIDTH  operand A.
- `in_b`  input  WIDTH  operand B (ignored by unary ops).
- `in_op`  input  3  operation select.
- `out_valid`  output  1  FIFO head holds a result.
- `out_ready`  input  1  consumer takes head this cycle.
- `out_data`  output  WIDTH  FIFO head result.
- `level`  output  $clog2(DEPTH)+1  current FIFO occupancy.
- `out_zero`  output  1  head result is all-zero (only with `BITWISE_PIPE_ZERO_FLAG_EN`).

## Operation
- Ops: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 pass a. All bitwise, full WIDTH, no carries.
- Push: `in_valid && in_ready` at a rising edge writes the result of the op on the current inputs into the FIFO tail.
- Pop: `out_valid && out_ready` at a rising edge advances the head.
- `in_ready` = `level < DEPTH`. It does not depend on `out_ready`, so there is no full-bypass path.
- `out_valid` = `level != 0`. `out_data` is driven from the head register, never from the inputs.
- Simultaneous push and pop: `level` is unchanged, and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` is tracked separately so that full and empty are unambiguous.
- Inputs with `in_valid` low are don't-care. Once out_valid is high, out_data holds stable until popped.
- Reset (asserted at any time, including mid-burst): `level`=0, pointers=0, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_zero`=0. Queued results are discarded.

## Timing
- Latency: a push at edge N makes the result visible at `out_data` with `out_valid`=1 after edge N, if the FIFO was empty. Otherwise it appears after the earlier entries have drained.
- Throughput: one result per cycle sustained when `out_ready` is held high.
- Full: `in_ready` falls in the cycle after the DEPTH-th unpopped push. It rises in the cycle after the first pop.
- Empty: `out_valid` falls in the cycle after the last pop, unless a push occurs on the same edge.
- Outputs `in_ready`, `out_valid`, `level`, `out_data` and `out_zero` are registered or decoded only from registered state. There is no combinational input→output path.
- Reset deassertion: the first push is permitted on the first rising edge after `reset` falls.

## Configuration
- Macro: `BITWISE_PIPE_ZERO_FLAG_EN`.
- Defined:
  - Each FIFO entry stores an extra bit, equal to (result == 0).
  - The `out_zero` port exists and tracks the head entry with the same timing as `out_data`.
  - `out_zero` is 0 when empty.
- Undefined: the `out_zero` port and its storage are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `reset` mid-cycle with 3 entries queued.
  - Required: `out_valid`=0, `level`=0, `in_ready`=1, `out_data`=0 immediately, before any clock edge.
- **Op sweep:** WIDTH=16, `in_a`=16'hAAAA, `in_b`=16'h0FF0, ops 000..111, `out_ready`=1.
  - Required outputs, in order: 5555, 0AA0, AFFA, A55A, F55F, 5005, 5AA5, AAAA.
  - Each appears one cycle after its push.
- **Fill/back-pressure:** DEPTH=4, `out_ready`=0, push 5 words.
  - Required: `in_ready` low after the 4th push, and the 5th is not accepted.
  - `level`=4.
  - Popping yields the 4 words in order.
- **Simultaneous push/pop at full:**
  - `level`=4, `out_ready`=1, `in_valid`=1: no push that cycle (`in_ready`=0), `level` goes to 3.
  - Next cycle, push and pop together: `level` stays 3.
- **Wrap-around:** stream 10 NOT ops of 16'h0000..16'h0009 through DEPTH=4 with `out_ready` toggling 1,0,1,0.
  - Required outputs: FFFF, FFFE, …, FFF6, in order, with no loss or duplication.
- **Zero flag (macro defined):** XOR of 16'h1234 with itself, then NOT of 16'h0000.
  - Required: `out_zero`=1 with `out_data`=0000, then `out_zero`=0 with `out_data`=FFFF.

Source files
------------

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: WIDTH-bit eight-op bitwise unit with valid/ready handshake and a DEPTH-entry result FIFO.
// Optional macro BITWISE_PIPE_ZERO_FLAG_EN adds a stored per-entry zero flag on out_zero.
module bitwise_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
  localparam int unsigned EW = WIDTH + 1;
`else
  localparam int unsigned EW = WIDTH;
`endif

  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_head;
  logic [LW-1:0]    r_level;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_result;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head_nxt;
  logic [LW-1:0]    w_level_nxt;
  logic [AW-1:0]    w_rd_inc;
  logic             w_push;
  logic             w_pop;

  // Operation decode
  always_comb begin
    w_result = in_a;
    case (in_op)
      3'b000: w_result = ~in_a;
      3'b001: w_result = in_a & in_b;
      3'b010: w_result = in_a | in_b;
      3'b011: w_result = in_a ^ in_b;
      3'b100: w_result = ~(in_a & in_b);
      3'b101: w_result = ~(in_a | in_b);
      3'b110: w_result = ~(in_a ^ in_b);
      3'b111: w_result = in_a;
    endcase
  end

`ifdef BITWISE_PIPE_ZERO_FLAG_EN
  assign w_entry  = {(w_result == '0), w_result};
  assign out_zero = r_head[WIDTH];
`else
  assign w_entry  = w_result;
`endif

  assign w_push   = in_valid && r_in_ready;
  assign w_pop    = r_out_valid && out_ready;
  assign w_rd_inc = r_rd_ptr + AW'(1);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Head register is the visible output; it loads the new result when it lands in an empty slot.
  always_comb begin
    w_head_nxt = r_head;
    if (w_level_nxt == '0) begin
      w_head_nxt = '0;
    end else if ((r_level == '0) || (w_pop && (r_level == LW'(1)))) begin
      w_head_nxt = w_entry;
    end else if (w_pop) begin
      w_head_nxt = r_mem[w_rd_inc];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      r_level     <= w_level_nxt;
      r_in_ready  <= (w_level_nxt != LW'(DEPTH));
      r_out_valid <= (w_level_nxt != '0);
      r_head      <= w_head_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head[WIDTH-1:0];
  assign level     = r_level;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Self-checking bench for bitwise_pipe: queue-based reference model with randomized and directed scenarios.
module tb_bitwise_pipe;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       level;
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q  [$];
  logic [WIDTH-1:0] popped_q [$];

  bitwise_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level)
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // One clock: drive, advance model by the handshake rules, sample 1 ns after the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic rdy, output logic accepted);
    logic push, pop;
    logic [WIDTH-1:0] head;
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = rdy;
    push = v && (model_q.size() < DEPTH);
    pop  = rdy && (model_q.size() != 0);
    head = out_data;
    @(posedge clk);
    if (pop) begin
      popped_q.push_back(head);
      void'(model_q.pop_front());
    end
    if (push) model_q.push_back(ref_op(op, a, b));
    accepted = push;
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) step(1'b0, 3'd0, '0, '0, 1'b1, acc);
    popped_q.delete();
  endtask

  task automatic test_reset();
    logic acc;
    logic [WIDTH-1:0] a;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b level=%0d ready=%b data=%h, required 0/0/1/0000",
               out_valid, level, in_ready, out_data);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 3'($urandom), 16'($urandom), 16'($urandom), 1'b0, acc);
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL reset_prefill: level=%0d required 3", level);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%b level=%0d ready=%b data=%h, required 0/0/1/0000",
               out_valid, level, in_ready, out_data);
    end
    model_q.delete();
    popped_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    a = 16'($urandom);
    step(1'b1, 3'd7, a, '0, 1'b0, acc);
    checks++;
    if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== a) begin
      errors++;
      $display("FAIL reset_first_push: valid=%b level=%0d data=%h, required 1/1/%h",
               out_valid, level, out_data, a);
    end
  endtask

  task automatic test_op_sweep();
    logic acc;
    logic [WIDTH-1:0] exp_tab [8];
    exp_tab = '{16'h5555, 16'h0AA0, 16'hAFFA, 16'hA55A, 16'hF55F, 16'h5005, 16'h5AA5, 16'hAAAA};
    drain();
    for (int op = 0; op < 8; op++) begin
      step(1'b1, 3'(op), 16'hAAAA, 16'h0FF0, 1'b1, acc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[op]) begin
        errors++;
        $display("FAIL op_sweep[%0d]: valid=%b data=%h, required 1/%h", op, out_valid, out_data, exp_tab[op]);
      end
    end
    step(1'b0, 3'd0, '0, '0, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL op_sweep_empty: valid=%b level=%0d, required 0/0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    logic acc;
    logic [WIDTH-1:0] w [5];
    drain();
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      step(1'b1, 3'd7, w[i], '0, 1'b0, acc);
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL fill_ready3: in_ready=%b required 1", in_ready);
        end
      end
      if (i >= 3) begin
        checks++;
        if (in_ready !== 1'b0 || level !== 3'd4) begin
          errors++;
          $display("FAIL fill_full[%0d]: in_ready=%b level=%0d, required 0/4", i, in_ready, level);
        end
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, '0, '0, 1'b1, acc);
    checks++;
    if (popped_q.size() != 4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain: popped=%0d valid=%b, required 4/0", popped_q.size(), out_valid);
    end
    for (int i = 0; i < 4 && i < popped_q.size(); i++) begin
      checks++;
      if (popped_q[i] !== w[i]) begin
        errors++; $display("FAIL fill_order[%0d]: got %h required %h", i, popped_q[i], w[i]);
      end
    end
  endtask

  task automatic test_full_simul();
    logic acc;
    drain();
    for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom), 16'($urandom), 16'($urandom), 1'b0, acc);
    step(1'b1, 3'd0, 16'h1111, '0, 1'b1, acc);
    checks++;
    if (level !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_only: level=%0d in_ready=%b, required 3/1", level, in_ready);
    end
    step(1'b1, 3'd0, 16'h2222, '0, 1'b1, acc);
    checks++;
    if (level !== 3'd3 || out_data !== model_q[0]) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d data=%h, required 3/%h", level, out_data, model_q[0]);
    end
  endtask

  task automatic test_wrap();
    logic acc;
    logic rdy;
    int idx, cyc;
    drain();
    idx = 0; cyc = 0; rdy = 1'b1;
    while (popped_q.size() < 10 && cyc < 100) begin
      step(idx < 10, 3'd0, 16'(idx), 16'($urandom), rdy, acc);
      if (acc) idx++;
      rdy = ~rdy;
      cyc++;
    end
    checks++;
    if (popped_q.size() != 10 || model_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: popped=%0d left=%0d, required 10/0", popped_q.size(), model_q.size());
    end
    for (int i = 0; i < 10 && i < popped_q.size(); i++) begin
      checks++;
      if (popped_q[i] !== 16'hFFFF - 16'(i)) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h required %h", i, popped_q[i], 16'hFFFF - 16'(i));
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic [WIDTH-1:0] exp_d;
    drain();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 2) != 0), acc);
      exp_d = (model_q.size() != 0) ? model_q[0] : '0;
      checks++;
      if (level !== 3'(model_q.size()) || out_valid !== (model_q.size() != 0) ||
          in_ready !== (model_q.size() < DEPTH) || out_data !== exp_d) begin
        errors++;
        $display("FAIL random[%0d]: level=%0d valid=%b ready=%b data=%h, required %0d/%b/%b/%h", i,
                 level, out_valid, in_ready, out_data, model_q.size(), model_q.size() != 0,
                 model_q.size() < DEPTH, exp_d);
      end
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
      checks++;
      if (out_zero !== (model_q.size() != 0 && model_q[0] == '0)) begin
        errors++; $display("FAIL random_zero[%0d]: out_zero=%b", i, out_zero);
      end
`endif
    end
  endtask

`ifdef BITWISE_PIPE_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic acc;
    drain();
    step(1'b1, 3'd3, 16'h1234, 16'h1234, 1'b0, acc);
    checks++;
    if (out_zero !== 1'b1 || out_data !== 16'h0000) begin
      errors++; $display("FAIL zero_set: out_zero=%b data=%h, required 1/0000", out_zero, out_data);
    end
    step(1'b1, 3'd0, 16'h0000, '0, 1'b1, acc);
    checks++;
    if (out_zero !== 1'b0 || out_data !== 16'hFFFF) begin
      errors++; $display("FAIL zero_clear: out_zero=%b data=%h, required 0/FFFF", out_zero, out_data);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_op_sweep();
    test_fill();
    test_full_simul();
    test_wrap();
    test_random();
`ifdef BITWISE_PIPE_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
